// File: rtl/prism_aux_datapath_pkg.sv
// rtl/prism_aux_datapath_pkg.sv - shared config addresses and mode bit indices for the PRISM aux datapath
package prism_aux_pkg;

  localparam logic [1:0] ADDR_MODE    = 2'd0;
  localparam logic [1:0] ADDR_PRELOAD = 2'd1;
  localparam logic [1:0] ADDR_COMPARE = 2'd2;
  localparam logic [1:0] ADDR_SHREG   = 2'd3;

  localparam int MODE_SHIFT_DIR  = 0;
  localparam int MODE_SHIFT_LONG = 1;
  localparam int MODE_AUTORELOAD = 2;
  localparam int MODE_W          = 3;

endpackage

// File: rtl/prism_aux_datapath_if.sv
// rtl/prism_aux_datapath_if.sv - FSM strobe and config-write bus into the PRISM aux datapath
interface prism_aux_datapath_if;

  logic        exec;
  logic        ctl_cnt1_dec;
  logic        ctl_cnt1_load;
  logic        ctl_cnt2_inc;
  logic        ctl_cnt2_clr;
  logic        ctl_shift;
  logic        ctl_latch;
  logic        comm_in;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;

  modport master (
    output exec, ctl_cnt1_dec, ctl_cnt1_load, ctl_cnt2_inc, ctl_cnt2_clr,
           ctl_shift, ctl_latch, comm_in, cfg_wr, cfg_addr, cfg_wdata
  );

  modport slave (
    input exec, ctl_cnt1_dec, ctl_cnt1_load, ctl_cnt2_inc, ctl_cnt2_clr,
          ctl_shift, ctl_latch, comm_in, cfg_wr, cfg_addr, cfg_wdata
  );

endinterface

// File: rtl/prism_aux_datapath_countdown.sv
// rtl/prism_aux_datapath_countdown.sv - cnt1 countdown with load/dec/autoreload/shift-in/low-bits-load priority
module prism_aux_countdown #(
  parameter int CNT1_W  = 24,
  parameter int SHIFT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic               autoreload_i,
  input  logic               shift_in_i,
  input  logic               comm_in_i,
  input  logic [CNT1_W-1:0]  preload_i,
  input  logic [SHIFT_W-1:0] shreg_i,
  output logic [CNT1_W-1:0]  cnt1_o,
  output logic               reload_o
);

  logic [CNT1_W-1:0] cnt1_q, cnt1_d;
  logic              reload;

  // A dec at zero without autoreload is still a dec: it claims priority and holds.
  always_comb begin
    cnt1_d = cnt1_q;
    reload = 1'b0;
    if (load_i && !dec_i) begin
      cnt1_d = preload_i;
    end else if (dec_i && !load_i) begin
      if (cnt1_q != '0) begin
        cnt1_d = cnt1_q - CNT1_W'(1);
      end else if (autoreload_i) begin
        cnt1_d = preload_i;
        reload = 1'b1;
      end
    end else if (shift_in_i) begin
      cnt1_d = {cnt1_q[CNT1_W-2:0], comm_in_i};
    end else if (load_i && dec_i) begin
      cnt1_d[SHIFT_W-1:0] = shreg_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt1_q <= '0;
    end else if (en_i) begin
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt1_o   = cnt1_q;
  assign reload_o = en_i & reload;

endmodule

// File: rtl/prism_aux_datapath.sv
// rtl/prism_aux_datapath.sv - PRISM counter/shifter/latch datapath top; PRISM_AUX_CAPTURE_EN adds the cnt1 capture register
module prism_aux_datapath
  import prism_aux_pkg::*;
#(
  parameter int CNT1_W  = 24,
  parameter int CNT2_W  = 5,
  parameter int SHIFT_W = 8,
  parameter int LAT_W   = 2,
  localparam int SC_W   = $clog2(CNT1_W) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  prism_aux_datapath_if.slave  ctl,
  input  logic [LAT_W-1:0]     lat_src_i,
  input  logic [LAT_W-1:0]     pin_in_i,
  output logic [CNT1_W-1:0]    cnt1_o,
  output logic [CNT2_W-1:0]    cnt2_o,
  output logic [SHIFT_W-1:0]   shreg_o,
  output logic                 shift_out_o,
  output logic [SC_W-1:0]      shift_cnt_o,
  output logic                 cnt1_zero_o,
  output logic                 cnt2_match_o,
  output logic                 cnt1_eq_sh_o,
  output logic                 shift_done_o,
  output logic [LAT_W-1:0]     latched_out_o,
  output logic [LAT_W-1:0]     latched_in_o,
  output logic                 event_pulse_o,
  output logic [CNT1_W-1:0]    cap_o
);

  logic [MODE_W-1:0]  mode_q;
  logic [CNT1_W-1:0]  preload_q;
  logic [CNT2_W-1:0]  compare_q;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic [SC_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [CNT2_W-1:0]  cnt2_q, cnt2_d;
  logic [LAT_W-1:0]   lat_out_q, lat_in_q;
  logic               match_prev_q;
  logic               event_q, event_d;
  logic               cnt2_match, reload;
  logic [SC_W-1:0]    shift_lim;
  logic               unused_wdata;

  wire shift_dir  = mode_q[MODE_SHIFT_DIR];
  wire shift_long = mode_q[MODE_SHIFT_LONG];
  wire do_shift   = ctl.exec & ctl.ctl_shift;

  assign unused_wdata = ^ctl.cfg_wdata;

  prism_aux_countdown #(.CNT1_W(CNT1_W), .SHIFT_W(SHIFT_W)) u_countdown (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (ctl.exec),
    .load_i       (ctl.ctl_cnt1_load),
    .dec_i        (ctl.ctl_cnt1_dec),
    .autoreload_i (mode_q[MODE_AUTORELOAD]),
    .shift_in_i   (shift_long & ctl.ctl_shift),
    .comm_in_i    (ctl.comm_in),
    .preload_i    (preload_q),
    .shreg_i      (shreg_q),
    .cnt1_o       (cnt1_o),
    .reload_o     (reload)
  );

  assign shift_lim  = shift_long ? SC_W'(CNT1_W - 1) : SC_W'(SHIFT_W - 1);
  assign cnt2_match = (cnt2_q == compare_q);

  always_comb begin
    shreg_d = shreg_q;
    if (ctl.cfg_wr && ctl.cfg_addr == ADDR_SHREG) begin
      shreg_d = ctl.cfg_wdata[SHIFT_W-1:0];
    end else if (do_shift && !shift_long) begin
      shreg_d = shift_dir ? {ctl.comm_in, shreg_q[SHIFT_W-1:1]}
                          : {shreg_q[SHIFT_W-2:0], ctl.comm_in};
    end

    // ">=" so a mode switch from long to short with a high count still wraps.
    shift_cnt_d = shift_cnt_q;
    if (do_shift) begin
      shift_cnt_d = (shift_cnt_q >= shift_lim) ? '0 : shift_cnt_q + SC_W'(1);
    end

    cnt2_d = cnt2_q;
    if (ctl.exec) begin
      if (ctl.ctl_cnt2_clr && !ctl.ctl_cnt2_inc) cnt2_d = '0;
      else if (ctl.ctl_cnt2_inc && !ctl.ctl_cnt2_clr) cnt2_d = cnt2_q + CNT2_W'(1);
    end

    event_d = (ctl.exec & ctl.ctl_cnt2_inc & ctl.ctl_cnt2_clr)
            | (cnt2_match & ~match_prev_q)
            | reload;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= '0;
      preload_q    <= '0;
      compare_q    <= '0;
      shreg_q      <= '0;
      shift_cnt_q  <= '0;
      cnt2_q       <= '0;
      lat_out_q    <= '0;
      lat_in_q     <= '0;
      // Mirrors cnt2_match, which is 1 in reset, so leaving reset is not a rising edge.
      match_prev_q <= 1'b1;
      event_q      <= 1'b0;
    end else begin
      if (ctl.cfg_wr) begin
        case (ctl.cfg_addr)
          ADDR_MODE:    mode_q    <= ctl.cfg_wdata[MODE_W-1:0];
          ADDR_PRELOAD: preload_q <= ctl.cfg_wdata[CNT1_W-1:0];
          ADDR_COMPARE: compare_q <= ctl.cfg_wdata[CNT2_W-1:0];
          default:      ;
        endcase
      end
      shreg_q      <= shreg_d;
      shift_cnt_q  <= shift_cnt_d;
      cnt2_q       <= cnt2_d;
      match_prev_q <= cnt2_match;
      event_q      <= event_d;
      if (ctl.exec && ctl.ctl_latch) begin
        lat_out_q <= lat_src_i;
        lat_in_q  <= pin_in_i;
      end
    end
  end

`ifdef PRISM_AUX_CAPTURE_EN
  logic [CNT1_W-1:0] cap_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q <= '0;
    end else if (ctl.exec && ctl.ctl_latch) begin
      cap_q <= cnt1_o;
    end
  end

  assign cap_o = cap_q;
`else
  assign cap_o = '0;
`endif

  assign cnt2_o        = cnt2_q;
  assign shreg_o       = shreg_q;
  assign shift_cnt_o   = shift_cnt_q;
  assign shift_out_o   = shift_long ? cnt1_o[CNT1_W-1]
                       : (shift_dir ? shreg_q[0] : shreg_q[SHIFT_W-1]);
  assign cnt1_zero_o   = (cnt1_o == '0);
  assign cnt2_match_o  = cnt2_match;
  assign cnt1_eq_sh_o  = (cnt1_o[SHIFT_W-1:0] == shreg_q);
  assign shift_done_o  = (shift_cnt_q == '0);
  assign latched_out_o = lat_out_q;
  assign latched_in_o  = lat_in_q;
  assign event_pulse_o = event_q;

endmodule
